// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM block.
// Carrier mode and count direction encodings.
package pwm_pkg;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_multi_if.sv
// Control/status bundle between register logic and pwm_multi.
// master drives controls; slave is the PWM block.
interface pwm_multi_if #(
    parameter int CH      = 4,
    parameter int R       = 8,
    parameter int TIMER_N = 15
);
    logic                    en;
    logic [TIMER_N-1:0]      final_value;
    logic                    center;
    logic                    duty_wr;
    logic [$clog2(CH)-1:0]   duty_ch;
    logic [R:0]              duty_in;
    logic                    load;
    logic [CH-1:0]           pwm_out;
    logic                    period_end;
    logic                    load_pending;

    modport master (
        output en, final_value, center,
        output duty_wr, duty_ch, duty_in, load,
        input  pwm_out, period_end, load_pending
    );

    modport slave (
        input  en, final_value, center,
        input  duty_wr, duty_ch, duty_in, load,
        output pwm_out, period_end, load_pending
    );
endinterface

// File: rtl/pwm_timebase.sv
// Shared prescaler and edge/center-aligned carrier counter.
// boundary flags the tick on which the carrier returns to zero.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int R       = 8,
    parameter int TIMER_N = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [TIMER_N-1:0] final_value,
    input  logic               center,
    output logic [R-1:0]       cnt,
    output logic               tick,
    output logic               boundary
);
    localparam logic [TIMER_N-1:0] P_ONE   = TIMER_N'(1);
    localparam logic [R-1:0]       C_ONE   = R'(1);
    localparam logic [R-1:0]       C_MAX   = '1;

    logic [TIMER_N-1:0] pcount_q, pcount_d;
    logic [R-1:0]       cnt_q, cnt_d;
    dir_e               dir_q, dir_d;
    mode_e              mode_q, mode_d;

    always_comb begin
        tick     = en && (pcount_q >= final_value);
        pcount_d = pcount_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        boundary = 1'b0;

        if (en) begin
            pcount_d = tick ? '0 : pcount_q + P_ONE;
        end

        if (tick) begin
            if (mode_q == MODE_EDGE) begin
                cnt_d    = cnt_q + C_ONE;
                boundary = (cnt_q == C_MAX);
            end else if (dir_q == DIR_UP) begin
                if (cnt_q == C_MAX) begin
                    cnt_d = cnt_q - C_ONE;
                    dir_d = DIR_DOWN;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end else begin
                // Clamp at zero so a stray down-count at 0 cannot wrap.
                boundary = (cnt_q <= C_ONE);
                cnt_d    = boundary ? '0 : cnt_q - C_ONE;
            end

            if (boundary) begin
                mode_d = center ? MODE_CENTER : MODE_EDGE;
                dir_d  = DIR_UP;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcount_q <= '0;
            cnt_q    <= '0;
            dir_q    <= DIR_UP;
            mode_q   <= MODE_EDGE;
        end else begin
            pcount_q <= pcount_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pwm_multi.sv
// CH-channel PWM: shared timebase, double-buffered duty registers,
// and one registered comparator per channel.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CH      = 4,
    parameter int R       = 8,
    parameter int TIMER_N = 15
) (
    input  logic       clk,
    input  logic       reset,
    pwm_multi_if.slave bus
);
    logic [R-1:0]  cnt;
    logic          tick;
    logic          boundary;
    logic          commit;
    logic [CH-1:0] wr_sel;
    logic [CH-1:0] pwm_vec;

    logic load_pending_q, load_pending_d;
    logic period_end_q, period_end_d;

    pwm_timebase #(
        .R       (R),
        .TIMER_N (TIMER_N)
    ) u_tb (
        .clk         (clk),
        .reset       (reset),
        .en          (bus.en),
        .final_value (bus.final_value),
        .center      (bus.center),
        .cnt         (cnt),
        .tick        (tick),
        .boundary    (boundary)
    );

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < CH; i++) begin
            wr_sel[i] = bus.duty_wr && (32'(bus.duty_ch) == i);
        end
    end

    always_comb begin
        commit         = boundary && (load_pending_q || bus.load);
        load_pending_d = load_pending_q;
        if (commit) begin
            load_pending_d = 1'b0;
        end else if (bus.load) begin
            load_pending_d = 1'b1;
        end
        period_end_d = boundary;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_pending_q <= 1'b0;
            period_end_q   <= 1'b0;
        end else begin
            load_pending_q <= load_pending_d;
            period_end_q   <= period_end_d;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [R:0] shadow_q, shadow_d;
        logic [R:0] active_q, active_d;
        logic       pwm_q, pwm_d;

        // Commit copies the pre-write shadow; a same-cycle write stays shadowed.
        always_comb begin
            shadow_d = wr_sel[i] ? bus.duty_in : shadow_q;
            active_d = commit ? shadow_q : active_q;
            pwm_d    = bus.en ? ({1'b0, cnt} < active_q) : pwm_q;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                shadow_q <= '0;
                active_q <= '0;
                pwm_q    <= 1'b0;
            end else begin
                shadow_q <= shadow_d;
                active_q <= active_d;
                pwm_q    <= pwm_d;
            end
        end

        assign pwm_vec[i] = pwm_q;
    end

    assign bus.pwm_out      = pwm_vec;
    assign bus.period_end   = period_end_q;
    assign bus.load_pending = load_pending_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: duty commit, mode, prescaler,
// reset and enable-freeze behaviour with hand-computed counts.
module tb_pwm_multi;
    localparam int CH      = 4;
    localparam int R       = 8;
    localparam int TIMER_N = 15;
    localparam int LIMIT   = 5000;

    logic clk = 1'b0;
    logic reset;

    int total = 0;
    int bad   = 0;
    int hi [CH];
    int pe_mid;
    int nzc;
    logic [CH-1:0] firstv;
    int n;
    int lpn;
    int h0;
    int frz;

    pwm_multi_if #(.CH(CH), .R(R), .TIMER_N(TIMER_N)) bus ();

    pwm_multi #(
        .CH      (CH),
        .R       (R),
        .TIMER_N (TIMER_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int val, input logic ld);
        bus.duty_wr = 1'b1;
        bus.duty_ch = ($clog2(CH))'(ch);
        bus.duty_in = (R+1)'(val);
        bus.load    = ld;
        step();
        bus.duty_wr = 1'b0;
        bus.load    = 1'b0;
    endtask

    task automatic wait_pe(output int cnt_steps);
        cnt_steps = 0;
        nzc = 0;
        do begin
            step();
            cnt_steps++;
            if (bus.pwm_out != '0) nzc++;
        end while (!bus.period_end && cnt_steps < LIMIT);
        chk("pe_seen", 32'(bus.period_end), 1);
    endtask

    task automatic wait_cnt(input int v);
        int k;
        k = 0;
        while (32'(dut.cnt) != v && k < LIMIT) begin
            step();
            k++;
        end
        chk("cnt_reach", 32'(dut.cnt), v);
    endtask

    task automatic measure(input int steps);
        for (int c = 0; c < CH; c++) hi[c] = 0;
        pe_mid = 0;
        for (int s = 1; s <= steps; s++) begin
            step();
            if (s == 1) firstv = bus.pwm_out;
            for (int c = 0; c < CH; c++) hi[c] += int'(bus.pwm_out[c]);
            if (s < steps && bus.period_end) pe_mid++;
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.en          = 1'b1;
        bus.final_value = '0;
        bus.center      = 1'b0;
        bus.duty_wr     = 1'b0;
        bus.duty_ch     = '0;
        bus.duty_in     = '0;
        bus.load        = 1'b0;
        repeat (3) step();
        chk("rst_pwm", 32'(bus.pwm_out), 0);
        chk("rst_pe", 32'(bus.period_end), 0);
        chk("rst_lp", 32'(bus.load_pending), 0);
        reset = 1'b0;

        // ch0 = 128, edge, tick every clock
        wr(0, 128, 1'b1);
        chk("t1_lp_rise", 32'(bus.load_pending), 1);
        wait_pe(n);
        chk("t1_first_pe", n, 255);
        chk("t1_lp_fall", 32'(bus.load_pending), 0);
        measure(256);
        chk("t1_first_hi", 32'(firstv[0]), 1);
        chk("t1_hi0", hi[0], 128);
        chk("t1_pe_mid", pe_mid, 0);
        chk("t1_pe_end", 32'(bus.period_end), 1);

        // 0 %, exactly 100 %, over-range
        wr(1, 0, 1'b0);
        wr(2, 256, 1'b0);
        wr(3, 300, 1'b1);
        wait_pe(n);
        chk("t2_pe_wait", n, 253);
        measure(256);
        chk("t2_firstv", 32'(firstv), 32'b1101);
        chk("t2_hi0", hi[0], 128);
        chk("t2_hi1", hi[1], 0);
        chk("t2_hi2", hi[2], 256);
        chk("t2_hi3", hi[3], 256);

        // mid-period write + load
        wait_cnt(99);
        wr(0, 32, 1'b1);
        chk("t3_lp_rise", 32'(bus.load_pending), 1);
        lpn = 0;
        h0 = 0;
        while (bus.load_pending && lpn < LIMIT) begin
            h0 += int'(bus.pwm_out[0]);
            lpn++;
            step();
        end
        chk("t3_lp_len", lpn, 156);
        chk("t3_old_hi", h0, 29);
        chk("t3_pe_at_fall", 32'(bus.period_end), 1);
        measure(256);
        chk("t3_hi0", hi[0], 32);

        // center-aligned, duty 64
        bus.center = 1'b1;
        wr(0, 64, 1'b1);
        wait_pe(n);
        chk("t4_pe_wait", n, 255);
        measure(510);
        chk("t4_hi0", hi[0], 127);
        chk("t4_hi2", hi[2], 510);
        chk("t4_pe_mid", pe_mid, 0);
        chk("t4_pe_end", 32'(bus.period_end), 1);

        // prescaler final_value = 3, then lowered to 1
        bus.center = 1'b0;
        wr(0, 128, 1'b1);
        wait_pe(n);
        chk("t5_pe_wait", n, 509);
        bus.final_value = TIMER_N'(3);
        measure(1024);
        chk("t5_hi0", hi[0], 512);
        chk("t5_pe_mid", pe_mid, 0);
        chk("t5_pe_end", 32'(bus.period_end), 1);
        step();
        step();
        bus.final_value = TIMER_N'(1);
        wait_pe(n);
        chk("t5_lower_pe", n + 2, 513);
        wait_pe(n);
        chk("t5_fv1_pe", n, 512);

        // reset mid-period with a load pending
        bus.final_value = '0;
        wr(0, 50, 1'b1);
        wait_cnt(200);
        chk("t6_lp_pre", 32'(bus.load_pending), 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_pwm", 32'(bus.pwm_out), 0);
        chk("t6_rst_lp", 32'(bus.load_pending), 0);
        chk("t6_rst_pe", 32'(bus.period_end), 0);
        step();
        reset = 1'b0;
        wr(0, 128, 1'b1);
        chk("t6_lp_new", 32'(bus.load_pending), 1);
        wait_pe(n);
        chk("t6_restart", n, 255);
        chk("t6_no_stale", nzc, 0);

        // en = 0 freezes outputs and counter; writes/load still taken
        repeat (10) step();
        chk("t7_pre", 32'(bus.pwm_out), 32'b0001);
        bus.en = 1'b0;
        wr(1, 256, 1'b1);
        frz = 0;
        for (int s = 0; s < 19; s++) begin
            step();
            if (bus.pwm_out != 4'b0001 || bus.period_end) frz++;
        end
        chk("t7_frozen", frz, 0);
        chk("t7_lp_en0", 32'(bus.load_pending), 1);
        bus.en = 1'b1;
        wait_pe(n);
        chk("t7_resume", n, 246);
        step();
        chk("t7_commit", 32'(bus.pwm_out), 32'b0011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator. Successor to the single-channel `pwm`: CH channels share one prescaler and one R-bit carrier counter, with edge- or center-aligned carrier selectable per period. Per-channel duty registers are double-buffered so new duties commit glitch-free at a period boundary. Sits between register/control logic and motor/LED driver pins.

## Interface
- `CH`, 4, channel count (≥2)
- `R`, 8, carrier resolution in bits
- `TIMER_N`, 15, prescaler width
- `clk` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-high
- `en` in 1: 1 = prescaler and carrier run; 0 = hold all state
- `final_value` in TIMER_N: prescaler terminal count; tick period = final_value+1 clocks
- `center` in 1: 0 = edge-aligned, 1 = center-aligned; sampled at boundary
- `duty_wr` in 1: write strobe for shadow duty
- `duty_ch` in $clog2(CH): target channel
- `duty_in` in R+1: duty value; values ≥ 2^R mean 100 %
- `load` in 1: request commit shadow → active at next boundary
- `pwm_out` out CH: registered channel outputs
- `period_end` out 1: one-clock pulse after each boundary
- `load_pending` out 1: commit requested, not yet applied

## Operation
- Reset values: pcount=0, cnt=0, dir=up, mode=edge, all shadow/active duties=0, pwm_out=0, period_end=0, load_pending=0.
- Prescaler: when en, tick = (pcount ≥ final_value); on tick pcount←0, else pcount+1. `≥` guarantees recovery if final_value is lowered below pcount. final_value=0 → tick every enabled clock.
- Carrier, edge mode: on tick cnt←cnt+1, wrapping 2^R−1→0. Period 2^R ticks.
- Carrier, center mode: counts up 0→2^R−1, then down to 0; dir flips at 2^R−1 and at 0. Period 2·(2^R−1) ticks.
- Boundary: the tick on which next cnt = 0 (edge: from 2^R−1; center: from 1 descending). At boundary: mode←center, dir←up, and if load_pending or load: all active←shadow simultaneously, load_pending←0.
- Compare: pwm_out[i] ← (cnt < active[i]). active=0 → constant low; active ≥ 2^R → constant high.
- duty_wr: shadow[duty_ch]←duty_in; duty_ch ≥ CH ignored. Shadow writes never alter active directly.
- load outside boundary sets load_pending; repeated load while pending has no further effect.
- Simultaneous duty_wr and committing boundary: commit takes the pre-write shadow; the write lands in shadow only.
- en=0: pcount, cnt, dir, pwm_out, and load_pending hold; writes and load still accepted.
- Reset mid-period: all state returns to reset values immediately; no partial commit.

## Timing
- pwm_out registered: reflects cnt value one clock earlier.
- New active duty visible on pwm_out one clock after the boundary clock.
- period_end asserted exactly one clock after the boundary clock, for one clock.
- load_pending rises the clock after load, falls the clock after commit.
- Prescaler tick to cnt update: same clock edge.

## Structure
- Package `pwm_pkg`: mode constants MODE_EDGE=0, MODE_CENTER=1; direction constants DIR_UP=1, DIR_DOWN=0.
- Sub-module `pwm_timebase`: prescaler, carrier counter, direction, mode latch; outputs cnt, tick, boundary.
- Top `pwm_multi`: shadow/active register arrays, load logic, CH comparators via generate.

## Test plan
- R=8, final_value=0, edge, ch0 duty 128 + load: after commit, pwm_out[0] high 128, low 128 clocks per 256-clock period; period_end every 256 clocks.
- ch1 duty 0, ch2 duty 256, ch3 duty 300 + load: ch1 constant 0, ch2 and ch3 constant 1 across full periods.
- Mid-period write ch0 duty 32 + load at cnt=100: old 128 waveform completes; 32 begins after boundary; load_pending high for exactly 156 clocks.
- center=1, final_value=0, ch0 duty 64: high 127 clocks centered on cnt=0, low 383; period 510 clocks.
- final_value=3, edge, duty 128: period 1024 clocks, high 512; lowering final_value to 1 while pcount=3 yields tick next clock, then 2-clock ticks.
- reset pulse while cnt=200, load pending: all outputs 0, load_pending 0, cnt restarts at 0; en=0 freezes pwm_out and cnt.
